// File: rtl/sc_isa_pkg.sv
// Shared ISA definitions for the instruction encoder: mnemonic ids, opcode/func
// constants, encoder FSM states and word-packing helpers.
package sc_isa_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
        MN_XOR  = 5'd4,  MN_SLL  = 5'd5,  MN_SRL  = 5'd6,  MN_SRA  = 5'd7,
        MN_JR   = 5'd8,  MN_ADDI = 5'd9,  MN_ANDI = 5'd10, MN_ORI  = 5'd11,
        MN_XORI = 5'd12, MN_LW   = 5'd13, MN_SW   = 5'd14, MN_BEQ  = 5'd15,
        MN_BNE  = 5'd16, MN_LUI  = 5'd17, MN_J    = 5'd18, MN_JAL  = 5'd19
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_XOR = 6'h26;
    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_SRL = 6'h02;
    localparam logic [5:0] FUNC_SRA = 6'h03;
    localparam logic [5:0] FUNC_JR  = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] func);
        return {OP_RTYPE, rs, rt, rd, shamt, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/sc_inst_pack.sv
// Combinational packer: symbolic instruction fields -> 32-bit MIPS word, plus an
// illegal-mnemonic flag for ids outside the supported set.
module sc_inst_pack
    import sc_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Field packing per mnemonic; shifts drop rs, jr drops rt/rd/shamt, lui drops rs
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  word = r_word(rs, rt, rd, shamt, FUNC_ADD);
            MN_SUB:  word = r_word(rs, rt, rd, shamt, FUNC_SUB);
            MN_AND:  word = r_word(rs, rt, rd, shamt, FUNC_AND);
            MN_OR:   word = r_word(rs, rt, rd, shamt, FUNC_OR);
            MN_XOR:  word = r_word(rs, rt, rd, shamt, FUNC_XOR);
            MN_SLL:  word = r_word(5'd0, rt, rd, shamt, FUNC_SLL);
            MN_SRL:  word = r_word(5'd0, rt, rd, shamt, FUNC_SRL);
            MN_SRA:  word = r_word(5'd0, rt, rd, shamt, FUNC_SRA);
            MN_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
            MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
            MN_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
            MN_ORI:  word = i_word(OP_ORI, rs, rt, imm);
            MN_XORI: word = i_word(OP_XORI, rs, rt, imm);
            MN_LW:   word = i_word(OP_LW, rs, rt, imm);
            MN_SW:   word = i_word(OP_SW, rs, rt, imm);
            MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
            MN_BNE:  word = i_word(OP_BNE, rs, rt, imm);
            MN_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
            MN_J:    word = j_word(OP_J, target);
            MN_JAL:  word = j_word(OP_JAL, target);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sc_inst_encoder.sv
// Program loader: encodes a stream of symbolic instructions and writes them to
// instruction memory from base_addr. Optional checksum output under ENC_CHECKSUM_EN.
module sc_inst_encoder
    import sc_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]       csum
`endif
);

    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    enc_state_t        state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] acc_cnt_r;
    logic [ADDR_W-1:0] index_r;
    logic              in_ready_r;
    logic              im_we_r;
    logic [ADDR_W-1:0] im_addr_r;
    logic [31:0]       im_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       word_s;
    logic              illegal_s;
    logic              xfer_s;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]       csum_r;
`endif

    sc_inst_pack u_pack (
        .mnem    (mnem),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (word_s),
        .illegal (illegal_s)
    );

    assign xfer_s = in_valid & in_ready_r;

    // Session FSM, accept/write counters and the registered memory write port
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            base_r     <= CNT_ZERO;
            len_r      <= CNT_ZERO;
            acc_cnt_r  <= CNT_ZERO;
            index_r    <= CNT_ZERO;
            in_ready_r <= 1'b0;
            im_we_r    <= 1'b0;
            im_addr_r  <= CNT_ZERO;
            im_wdata_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            csum_r     <= 32'h0000_0000;
`endif
        end else begin
            im_we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_r    <= base_addr;
                        len_r     <= prog_len;
                        acc_cnt_r <= CNT_ZERO;
                        index_r   <= CNT_ZERO;
                        err_r     <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                        csum_r    <= 32'h0000_0000;
`endif
                        if (prog_len == CNT_ZERO) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            busy_r     <= 1'b0;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ST_RUN;
                            done_r     <= 1'b0;
                            busy_r     <= 1'b1;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Illegal ids are swallowed: they flag err but never reach memory
                    if (xfer_s) begin
                        if (illegal_s) begin
                            err_r <= 1'b1;
                        end else begin
                            im_we_r    <= 1'b1;
                            im_addr_r  <= base_r + acc_cnt_r;
                            im_wdata_r <= word_s;
                            acc_cnt_r  <= acc_cnt_r + CNT_ONE;
                            if (acc_cnt_r + CNT_ONE == len_r) begin
                                in_ready_r <= 1'b0;
                            end
                        end
                    end
                    if (im_we_r) begin
                        index_r <= index_r + CNT_ONE;
`ifdef ENC_CHECKSUM_EN
                        csum_r  <= csum_r ^ im_wdata_r;
`endif
                        if (index_r + CNT_ONE == len_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign im_we    = im_we_r;
    assign im_addr  = im_addr_r;
    assign im_wdata = im_wdata_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
`ifdef ENC_CHECKSUM_EN
    assign csum     = csum_r;
`endif

endmodule

// File: tb/tb_sc_inst_encoder.sv
// Directed bench for sc_inst_encoder: expected writes queued at drive time and
// popped by a write monitor; status outputs checked inline.
module tb_sc_inst_encoder;
    import sc_isa_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  prog_len;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem, rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        busy, done, err;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] csum;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sc_inst_encoder #(.ADDR_W(8)) dut (
        .clock     (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .prog_len  (prog_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm       (imm),
        .target    (target),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef ENC_CHECKSUM_EN
        ,.csum     (csum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every im_we cycle must match the oldest queued expectation
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {24'h0, im_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_addr", {24'h0, im_addr}, {24'h0, e.addr});
                chk("write_data", im_wdata, e.data);
            end
        end
    end

    task automatic start_session(input logic [7:0] b, input logic [7:0] l);
        base_addr = b;
        prog_len  = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] rs_v, input logic [4:0] rt_v,
                        input logic [4:0] rd_v, input logic [4:0] sh_v, input logic [15:0] imm_v,
                        input logic [25:0] tgt_v, input logic wr, input logic [7:0] ea,
                        input logic [31:0] ed, output int waited);
        mnem = m; rs = rs_v; rt = rt_v; rd = rd_v; shamt = sh_v; imm = imm_v; target = tgt_v;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("ready_before_transfer", {31'h0, in_ready}, 32'h1);
        if (wr && in_ready === 1'b1) sb.push_back('{addr: ea, data: ed});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        resetn = 1'b0; start = 1'b0; base_addr = 8'h00; prog_len = 8'h00; in_valid = 1'b0;
        mnem = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 16'h0; target = 26'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_im_we",    {31'h0, im_we},    32'h0);
        chk("rst_busy",     {31'h0, busy},     32'h0);
        chk("rst_done",     {31'h0, done},     32'h0);
        chk("rst_err",      {31'h0, err},      32'h0);
        chk("rst_im_addr",  {24'h0, im_addr},  32'h0);
        chk("rst_im_wdata", im_wdata,          32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Zero-length session goes straight to DONE without writing
        start_session(8'h80, 8'h00);
        chk("len0_done",  {31'h0, done},     32'h1);
        chk("len0_busy",  {31'h0, busy},     32'h0);
        chk("len0_ready", {31'h0, in_ready}, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // Single add at 0x10
        start_session(8'h10, 8'h01);
        chk("a_ready", {31'h0, in_ready}, 32'h1);
        chk("a_busy",  {31'h0, busy},     32'h1);
        chk("a_done",  {31'h0, done},     32'h0);
        send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 8'h10, 32'h0022_1820, w);
        chk("a_we_now",   {31'h0, im_we},    32'h1);
        chk("a_ready_lo", {31'h0, in_ready}, 32'h0);
        chk("a_done_lo",  {31'h0, done},     32'h0);
        @(posedge clk); #1;
        chk("a_done_hi", {31'h0, done}, 32'h1);
        chk("a_busy_lo", {31'h0, busy}, 32'h0);

        // Back-to-back stream, re-armed from DONE
        start_session(8'h20, 8'h03);
        chk("b_done_cleared", {31'h0, done}, 32'h0);
        send(MN_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 8'h20, 32'h2001_0005, w);
        chk("b_stall0", w, 32'd0);
        send(MN_LW, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 8'h21, 32'h8C22_0004, w);
        chk("b_stall1", w, 32'd0);
        send(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 8'h22, 32'h0800_0010, w);
        chk("b_stall2", w, 32'd0);
        @(posedge clk); #1;
        chk("b_done", {31'h0, done}, 32'h1);

        // Forced fields and an illegal mnemonic mid-stream
        start_session(8'h40, 8'h04);
        send(MN_SLL, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b1, 8'h40, 32'h0002_1900, w);
        send(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 8'h00, 32'h0, w);
        chk("c_err_set",   {31'h0, err},   32'h1);
        chk("c_no_write",  {31'h0, im_we}, 32'h0);
        send(MN_SUB, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1, 8'h41, 32'h0085_3022, w);
        send(MN_JR, 5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 8'h42, 32'h03E0_0008, w);
        chk("c_ready_last", {31'h0, in_ready}, 32'h1);
        send(MN_LUI, 5'd5, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 8'h43, 32'h3C09_1234, w);
        @(posedge clk); #1;
        chk("c_done", {31'h0, done}, 32'h1);
        chk("c_err_sticky", {31'h0, err}, 32'h1);

        // Address wrap past the top of memory; re-arm clears err
        start_session(8'hFE, 8'h04);
        chk("d_err_cleared", {31'h0, err}, 32'h0);
        send(MN_ORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'hABCD, 26'h0, 1'b1, 8'hFE, 32'h3443_ABCD, w);
        send(MN_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 8'hFF, 32'h1022_FFFF, w);
        send(MN_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 8'h00, 32'h0FFF_FFFF, w);
        send(MN_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1, 8'h01, 32'hAFBF_0008, w);
        @(posedge clk); #1;
        chk("d_done", {31'h0, done}, 32'h1);

        // Start while RUN is ignored; reset with a pending write aborts the session
        start_session(8'h50, 8'h03);
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 8'h00, 32'h0, w);
        start_session(8'h60, 8'h01);
        chk("e_ignore_busy",  {31'h0, busy},     32'h1);
        chk("e_ignore_ready", {31'h0, in_ready}, 32'h1);
        send(MN_XOR, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 8'h50, 32'h0022_1826, w);
        chk("e_still_ready", {31'h0, in_ready}, 32'h1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("e_rst_we",    {31'h0, im_we},    32'h0);
        chk("e_rst_busy",  {31'h0, busy},     32'h0);
        chk("e_rst_done",  {31'h0, done},     32'h0);
        chk("e_rst_err",   {31'h0, err},      32'h0);
        chk("e_rst_ready", {31'h0, in_ready}, 32'h0);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
